// File: rtl/fir_pkg.sv
// fir_pkg: shared defaults and state encoding for the FIR sequencer
package fir_pkg;

    localparam int NTAPS_DEF = 31;
    localparam int DW_DEF    = 10;
    localparam int CW_DEF    = 16;
    localparam int AW_DEF    = 32;

    // coef_addr and the delay-line pointers are 5 bits, so NTAPS must not exceed 32
    localparam int PTR_W     = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/fir_delay_line.sv
// fir_delay_line: circular sample buffer with one write port, one async read port, async-low clear
module fir_delay_line import fir_pkg::*; #(
    parameter int DEPTH = NTAPS_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [DW-1:0]    wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [DW-1:0]    rd_data
);

    logic [DW-1:0] mem [0:DEPTH-1];

    assign rd_data = mem[rd_addr];

    // store the accepted sample; reset wipes every tap so a restarted filter sees only zeros
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/fir_sequencer.sv
// fir_sequencer: time-multiplexed single-MAC FIR filter; define FIR_SATURATE_EN to clamp the output instead of truncating
module fir_sequencer import fir_pkg::*; #(
    parameter int NTAPS = NTAPS_DEF,
    parameter int DW    = DW_DEF,
    parameter int CW    = CW_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DW-1:0]        sample,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    output logic [PTR_W-1:0]     coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic [DW-1:0]        filtered,
    output logic                 filtered_valid,
    output logic                 busy
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(NTAPS - 1);

    state_t                state, state_nx;
    logic                  take, acc_en;
    logic [PTR_W-1:0]      cnt, wr_ptr, rd_ptr;
    logic [DW-1:0]         x_rd, x_q, result;
    logic signed [AW-1:0]  acc, prod, acc_sum;

    assign take         = sample_valid && sample_ready;
    assign sample_ready = (state == IDLE);
    assign busy         = !sample_ready;
    assign coef_addr    = (state == MAC) ? cnt : '0;

    // sample is zero-extended to stay positive as a signed operand
    assign prod    = AW'($signed({1'b0, x_q})) * AW'(coef_data);
    assign acc_sum = acc + prod;

`ifdef FIR_SATURATE_EN
    localparam logic signed [AW-1:0] MAXV = AW'((1 << DW) - 1);
    logic signed [AW-1:0] shifted;
    assign shifted = acc_sum >>> (CW - 1);
    assign result  = (shifted < 0) ? '0 : (shifted > MAXV) ? '1 : DW'(shifted);
`else
    assign result  = DW'(acc_sum >>> (CW - 1));
`endif

    fir_delay_line #(.DEPTH(NTAPS), .DW(DW)) u_delay_line (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (take),
        .wr_addr (wr_ptr),
        .wr_data (sample),
        .rd_addr (rd_ptr),
        .rd_data (x_rd)
    );

    // next state: one MAC cycle per tap, then a single drain cycle for the last product
    always_comb begin
        state_nx = take                          ? MAC   :
                   (state == MAC && cnt == LAST) ? DRAIN :
                   (state == DRAIN)              ? IDLE  : state;
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // datapath: read tap k alongside coef_addr=k, accumulate one cycle later when coef_data arrives
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt            <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            x_q            <= '0;
            acc_en         <= 1'b0;
            acc            <= '0;
            filtered       <= '0;
            filtered_valid <= 1'b0;
        end else begin
            filtered_valid <= (state == DRAIN);
            acc_en         <= (state == MAC);
            x_q            <= x_rd;
            if (take) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                rd_ptr <= wr_ptr;
                cnt    <= '0;
                acc    <= '0;
            end else if (acc_en) begin
                acc <= acc_sum;
            end
            if (state == MAC) begin
                cnt    <= cnt + 1'b1;
                rd_ptr <= (rd_ptr == '0) ? LAST : rd_ptr - 1'b1;
            end
            if (state == DRAIN) filtered <= result;
        end
    end

endmodule

// File: tb/tb_fir_sequencer.sv
// tb_fir_sequencer: scoreboard bench for fir_sequencer (honours FIR_SATURATE_EN for expected values)
module tb_fir_sequencer;

    localparam int NT = 31;

    logic               clk = 1'b0;
    logic               reset;
    logic [9:0]         sample;
    logic               sample_valid;
    logic               sample_ready;
    logic [4:0]         coef_addr;
    logic signed [15:0] coef_data;
    logic [9:0]         filtered;
    logic               filtered_valid;
    logic               busy;

    logic signed [15:0] rom [0:31];
    int                 hist[$];
    logic [9:0]         exp_q[$];
    int                 hs_q[$];
    int                 cyc = 0;
    int                 checks = 0;
    int                 failures = 0;

    fir_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .sample         (sample),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .coef_addr      (coef_addr),
        .coef_data      (coef_data),
        .filtered       (filtered),
        .filtered_valid (filtered_valid),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // coefficient ROM with one cycle of read latency
    always @(posedge clk) coef_data <= rom[coef_addr];

    function automatic logic [9:0] model();
        longint acc = 0;
        for (int k = 0; k < hist.size() && k < NT; k++) acc += longint'(hist[k]) * longint'(rom[k]);
        acc = acc >>> 15;
`ifdef FIR_SATURATE_EN
        if (acc < 0) return 10'd0;
        if (acc > 1023) return 10'd1023;
`endif
        return acc[9:0];
    endfunction

    // drive one cycle at the falling edge; record handshakes and pop expectations on strobes
    task automatic step(input logic v, input logic [9:0] s, output logic hs, output logic fv,
                        output logic [9:0] e, output int l);
        @(negedge clk);
        sample_valid = v;
        sample       = s;
        hs = v && sample_ready;
        fv = filtered_valid;
        e  = 'x;
        l  = -1;
        if (hs) begin
            hist.push_front(int'(s));
            if (hist.size() > NT) void'(hist.pop_back());
            exp_q.push_back(model());
            hs_q.push_back(cyc);
        end
        if (fv && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            l = cyc - hs_q.pop_front();
        end
    endtask

    task automatic run_one(input logic [9:0] s, output logic [9:0] got, output logic [9:0] e,
                           output int l, output bit ok);
        logic hs, fv;
        logic [9:0] ee;
        int ll;
        bit done = 0;
        ok = 0; got = 'x; e = 'x; l = -1;
        for (int i = 0; i < 100 && !done; i++) begin
            step(1'b1, s, hs, fv, ee, ll);
            done = hs;
        end
        if (!done) return;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            step(1'b0, s, hs, fv, ee, ll);
            if (fv) begin
                got = filtered; e = ee; l = ll; ok = 1; done = 1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; sample_valid = 1'b0; sample = '0;
        for (int k = 0; k < 32; k++) rom[k] = '0;
        repeat (3) @(negedge clk);
        checks++; if (sample_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", sample_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (filtered !== 10'd0) begin failures++; $display("FAIL rst_filtered got=%0d exp=0", filtered); end
        checks++; if (filtered_valid !== 1'b0) begin failures++; $display("FAIL rst_fv got=%b exp=0", filtered_valid); end
        checks++; if (coef_addr !== 5'd0) begin failures++; $display("FAIL rst_coef_addr got=%0d exp=0", coef_addr); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (sample_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%b exp=1", sample_ready); end
    endtask

    task automatic test_dc();
        logic [9:0] got, e;
        int l;
        bit ok;
        for (int k = 0; k < 32; k++) rom[k] = 16'sd1024;
        for (int i = 0; i < NT; i++) begin
            run_one(10'd512, got, e, l, ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL dc_timeout sample=%0d", i); end
            else begin
                checks++; if (got !== e) begin failures++; $display("FAIL dc_out[%0d] got=%0d exp=%0d", i, got, e); end
                checks++; if (l != 33) begin failures++; $display("FAIL dc_latency[%0d] got=%0d exp=33", i, l); end
            end
        end
        checks++; if (got !== 10'd496) begin failures++; $display("FAIL dc_final got=%0d exp=496", got); end
    endtask

    task automatic test_impulse();
        logic [9:0] got, e;
        int l;
        bit ok;
        int exp_n;
        for (int k = 0; k < 32; k++) rom[k] = 16'(100 * k);
        for (int i = 0; i < NT; i++) run_one(10'd0, got, e, l, ok);
        for (int n = 0; n < NT; n++) begin
            run_one(n == 0 ? 10'd1000 : 10'd0, got, e, l, ok);
            exp_n = (100000 * n) / 32768;
            checks++;
            if (!ok) begin failures++; $display("FAIL imp_timeout n=%0d", n); end
            else begin
                checks++; if (got !== 10'(exp_n)) begin failures++; $display("FAIL imp_out[%0d] got=%0d exp=%0d", n, got, exp_n); end
                checks++; if (got !== e) begin failures++; $display("FAIL imp_model[%0d] got=%0d exp=%0d", n, got, e); end
            end
            if (n == 5) begin
                checks++; if (got !== 10'd15) begin failures++; $display("FAIL imp_n5 got=%0d exp=15", got); end
            end
        end
    endtask

    task automatic test_saturation();
        logic [9:0] got, e;
        int l;
        bit ok;
        for (int k = 0; k < 32; k++) rom[k] = 16'sh7FFF;
        for (int i = 0; i < NT; i++) begin
            run_one(10'd1023, got, e, l, ok);
            checks++; if (!ok || got !== e) begin failures++; $display("FAIL sat_pos[%0d] got=%0d exp=%0d", i, got, e); end
        end
`ifdef FIR_SATURATE_EN
        checks++; if (got !== 10'd1023) begin failures++; $display("FAIL sat_pos_final got=%0d exp=1023", got); end
`else
        checks++; if (got !== 10'd992) begin failures++; $display("FAIL sat_pos_final got=%0d exp=992", got); end
`endif
        for (int k = 0; k < 32; k++) rom[k] = -16'sd1024;
        for (int i = 0; i < NT; i++) begin
            run_one(10'd512, got, e, l, ok);
            checks++; if (!ok || got !== e) begin failures++; $display("FAIL sat_neg[%0d] got=%0d exp=%0d", i, got, e); end
        end
`ifdef FIR_SATURATE_EN
        checks++; if (got !== 10'd0) begin failures++; $display("FAIL sat_neg_final got=%0d exp=0", got); end
`else
        checks++; if (got !== 10'd528) begin failures++; $display("FAIL sat_neg_final got=%0d exp=528", got); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [9:0] bp [0:39];
        logic hs, fv;
        logic [9:0] e;
        int l, idx = 0, outs = 0, prev = -1, spacing_bad = 0, ready_bad = 0;
        for (int k = 0; k < 32; k++) rom[k] = 16'(int'($urandom_range(0, 4000)) - 2000);
        for (int i = 0; i < 40; i++) bp[i] = 10'($urandom_range(0, 1023));
        for (int c = 0; c < 40 * 33 + 200 && outs < 40; c++) begin
            step(idx < 40, bp[idx < 40 ? idx : 0], hs, fv, e, l);
            if (sample_ready === busy) ready_bad++;
            if (hs) begin
                if (prev >= 0 && cyc - prev != 33) spacing_bad++;
                prev = cyc;
                idx++;
            end
            if (fv) begin
                checks++; if (filtered !== e) begin failures++; $display("FAIL b2b_out[%0d] got=%0d exp=%0d", outs, filtered, e); end
                checks++; if (l != 33) begin failures++; $display("FAIL b2b_latency[%0d] got=%0d exp=33", outs, l); end
                outs++;
            end
        end
        sample_valid = 1'b0;
        checks++; if (outs != 40) begin failures++; $display("FAIL b2b_outputs got=%0d exp=40", outs); end
        checks++; if (idx != 40) begin failures++; $display("FAIL b2b_accepted got=%0d exp=40", idx); end
        checks++; if (spacing_bad != 0) begin failures++; $display("FAIL b2b_spacing bad=%0d exp=0", spacing_bad); end
        checks++; if (ready_bad != 0) begin failures++; $display("FAIL b2b_ready_busy bad=%0d exp=0", ready_bad); end
    endtask

    task automatic test_reset_mid_mac();
        logic [9:0] got, e;
        logic hs, fv;
        int l, fv_seen = 0;
        bit ok, found = 0;
        for (int k = 0; k < 32; k++) rom[k] = 16'(int'($urandom_range(0, 4000)) - 2000);
        rom[0] = 16'sd20000;
        for (int i = 0; i < 3; i++) run_one(10'($urandom_range(1, 1023)), got, e, l, ok);
        for (int i = 0; i < 100 && !found; i++) begin
            step(1'b1, 10'd900, hs, fv, e, l);
            found = hs;
        end
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            step(1'b0, 10'd0, hs, fv, e, l);
            found = (coef_addr == 5'd12);
        end
        checks++; if (!found) begin failures++; $display("FAIL rmid_reach_addr12 got=timeout exp=coef_addr 12"); end
        reset = 1'b0;
        #1;
        checks++; if (filtered !== 10'd0) begin failures++; $display("FAIL rmid_filtered got=%0d exp=0", filtered); end
        checks++; if (coef_addr !== 5'd0) begin failures++; $display("FAIL rmid_coef_addr got=%0d exp=0", coef_addr); end
        checks++; if (sample_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", sample_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (filtered_valid !== 1'b0) fv_seen++;
        end
        reset = 1'b1;
        hist.delete(); exp_q.delete(); hs_q.delete();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (filtered_valid !== 1'b0) fv_seen++;
        end
        checks++; if (fv_seen != 0) begin failures++; $display("FAIL rmid_no_strobe got=%0d exp=0", fv_seen); end
        run_one(10'd777, got, e, l, ok);
        checks++; if (!ok || got !== e) begin failures++; $display("FAIL rmid_fresh1 got=%0d exp=%0d", got, e); end
        checks++; if (got !== 10'd474) begin failures++; $display("FAIL rmid_fresh1_const got=%0d exp=474", got); end
        run_one(10'd333, got, e, l, ok);
        checks++; if (!ok || got !== e) begin failures++; $display("FAIL rmid_fresh2 got=%0d exp=%0d", got, e); end
    endtask

    initial begin
        test_reset();
        test_dc();
        test_impulse();
        test_saturation();
        test_back_to_back();
        test_reset_mid_mac();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
